// File: rtl/fft4_s2p_buffer.sv
// Serial-to-parallel front end for fft4: gathers four complex samples into a frame
// and presents them in parallel with a one-cycle valid pulse, resyncing on start-of-frame.
module fft4_s2p_buffer #(
   parameter int NB_DATA  = 8,
   parameter int NBF_DATA = 7
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_enable,
   input  logic                   i_valid,
   input  logic                   i_sof,
   input  logic [2*NB_DATA-1:0]   i_data,
   output logic [2*NB_DATA-1:0]   o_x0,
   output logic [2*NB_DATA-1:0]   o_x1,
   output logic [2*NB_DATA-1:0]   o_x2,
   output logic [2*NB_DATA-1:0]   o_x3,
   output logic                   o_valid,
   output logic                   o_drop
);

   // The fractional point only travels with the data; the word width is all that matters here.
   localparam int W = 2*NB_DATA + 0*NBF_DATA;

   logic       accept;
   logic [1:0] wr_idx_reg;

   assign accept = i_enable & i_valid;

   // Slots 0..2 only: the fourth sample goes straight to o_x3 on the completing edge.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_slot
         logic         load;
         logic [W-1:0] slot_reg;

         assign load = accept & (i_sof ? (gi == 0) : (wr_idx_reg == 2'(gi)));

         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               slot_reg <= '0;
            end else if (load) begin
               slot_reg <= i_data;
            end
         end
      end
   endgenerate

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_idx_reg <= 2'd0;
         o_x0       <= '0;
         o_x1       <= '0;
         o_x2       <= '0;
         o_x3       <= '0;
         o_valid    <= 1'b0;
         o_drop     <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         o_drop  <= 1'b0;
         if (accept) begin
            if (i_sof) begin
               // A start-of-frame always wins, even over a sample that would have completed the frame.
               wr_idx_reg <= 2'd1;
               o_drop     <= (wr_idx_reg != 2'd0);
            end else begin
               wr_idx_reg <= wr_idx_reg + 2'd1;
               if (wr_idx_reg == 2'd3) begin
                  o_x0    <= g_slot[0].slot_reg;
                  o_x1    <= g_slot[1].slot_reg;
                  o_x2    <= g_slot[2].slot_reg;
                  o_x3    <= i_data;
                  o_valid <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_fft4_s2p_buffer.sv
// Bench for fft4_s2p_buffer: stimulus rows with expected pulses, plus a frame scoreboard
// filled as completing samples are driven and drained whenever the DUT raises o_valid.
module tb_fft4_s2p_buffer;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_enable;
   logic        i_valid;
   logic        i_sof;
   logic [15:0] i_data;
   logic [15:0] o_x0, o_x1, o_x2, o_x3;
   logic        o_valid;
   logic        o_drop;

   always #5 i_clk = ~i_clk;

   fft4_s2p_buffer #(.NB_DATA(8), .NBF_DATA(7)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_valid(i_valid),
      .i_sof(i_sof), .i_data(i_data),
      .o_x0(o_x0), .o_x1(o_x1), .o_x2(o_x2), .o_x3(o_x3),
      .o_valid(o_valid), .o_drop(o_drop)
   );

   typedef struct {
      logic        en;
      logic        vld;
      logic        sof;
      logic [15:0] data;
      logic        exp_valid;
      logic        exp_drop;
      logic [63:0] frame;
   } vec_t;

   vec_t        tbl[$];
   logic [63:0] exp_q[$];
   logic [63:0] last_frame;
   int          tests = 0;
   int          fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic en, input logic vld, input logic sof, input logic [15:0] data,
                      input logic ev, input logic ed, input logic [63:0] frame);
      vec_t v;
      v.en = en; v.vld = vld; v.sof = sof; v.data = data;
      v.exp_valid = ev; v.exp_drop = ed; v.frame = frame;
      tbl.push_back(v);
   endtask

   task automatic add_frame(input logic sof, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
      add(1, 1, sof, a, 0, 0, '0);
      add(1, 1, 0,   b, 0, 0, '0);
      add(1, 1, 0,   c, 0, 0, '0);
      add(1, 1, 0,   d, 1, 0, {a, b, c, d});
   endtask

   task automatic run_table();
      logic [63:0] f;
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge i_clk);
         i_enable = tbl[i].en;
         i_valid  = tbl[i].vld;
         i_sof    = tbl[i].sof;
         i_data   = tbl[i].data;
         if (tbl[i].exp_valid) exp_q.push_back(tbl[i].frame);
         @(posedge i_clk);
         #1;
         $display("[TB] t=%0t en=%b vld=%b sof=%b data=%h -> valid=%b drop=%b x=%h_%h_%h_%h",
                  $time, tbl[i].en, tbl[i].vld, tbl[i].sof, tbl[i].data,
                  o_valid, o_drop, o_x0, o_x1, o_x2, o_x3);
         check("o_valid", 64'(o_valid), 64'(tbl[i].exp_valid));
         check("o_drop", 64'(o_drop), 64'(tbl[i].exp_drop));
         if (o_valid) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL scoreboard: got unexpected frame %h_%h_%h_%h expected none",
                        o_x0, o_x1, o_x2, o_x3);
            end else begin
               f = exp_q.pop_front();
               check("frame", {o_x0, o_x1, o_x2, o_x3}, f);
               last_frame = f;
            end
         end else begin
            check("hold", {o_x0, o_x1, o_x2, o_x3}, last_frame);
         end
      end
      tbl.delete();
      @(negedge i_clk);
      i_valid = 1'b0;
      i_sof   = 1'b0;
   endtask

   initial begin
      i_rst = 1'b1; i_enable = 1'b0; i_valid = 1'b0; i_sof = 1'b0; i_data = '0;
      last_frame = '0;

      // Reset state
      repeat (2) @(posedge i_clk);
      #1;
      check("rst_x", {o_x0, o_x1, o_x2, o_x3}, 64'd0);
      check("rst_valid", 64'(o_valid), 64'd0);
      check("rst_drop", 64'(o_drop), 64'd0);
      @(negedge i_clk);
      i_rst = 1'b0;

      // Single frame, then idle cycles to confirm the frame is held
      add_frame(1, 16'h4000, 16'h0040, 16'hC000, 16'h00C0);
      add(1, 0, 0, 16'hDEAD, 0, 0, '0);
      add(1, 0, 0, 16'hBEEF, 0, 0, '0);
      run_table();

      // Streaming: three back-to-back frames
      add_frame(1, 16'h0101, 16'h0202, 16'h0303, 16'h0404);
      add_frame(1, 16'h8000, 16'h7FFF, 16'hFF01, 16'h0180);
      add_frame(1, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
      run_table();

      // Gaps then enable low with valid high: ignored samples
      add(1, 1, 1, 16'hA1A1, 0, 0, '0);
      add(1, 0, 0, 16'h1111, 0, 0, '0);
      add(1, 0, 0, 16'h2222, 0, 0, '0);
      add(1, 0, 0, 16'h3333, 0, 0, '0);
      add(0, 1, 0, 16'h4444, 0, 0, '0);
      add(0, 1, 1, 16'h5555, 0, 0, '0);
      add(1, 1, 0, 16'hB2B2, 0, 0, '0);
      add(1, 1, 0, 16'hC3C3, 0, 0, '0);
      add(1, 1, 0, 16'hD4D4, 1, 0, {16'hA1A1, 16'hB2B2, 16'hC3C3, 16'hD4D4});
      run_table();

      // Resync after two samples
      add(1, 1, 1, 16'h0A0A, 0, 0, '0);
      add(1, 1, 0, 16'h0B0B, 0, 0, '0);
      add(1, 1, 1, 16'h7F7F, 0, 1, '0);
      add(1, 1, 0, 16'h0C0C, 0, 0, '0);
      add(1, 1, 0, 16'h0D0D, 0, 0, '0);
      add(1, 1, 0, 16'h0E0E, 1, 0, {16'h7F7F, 16'h0C0C, 16'h0D0D, 16'h0E0E});
      // Start-of-frame on what would have been the completing sample
      add(1, 1, 1, 16'h1010, 0, 0, '0);
      add(1, 1, 0, 16'h2020, 0, 0, '0);
      add(1, 1, 0, 16'h3030, 0, 0, '0);
      add(1, 1, 1, 16'h4040, 0, 1, '0);
      add(1, 1, 0, 16'h5050, 0, 0, '0);
      add(1, 1, 0, 16'h6060, 0, 0, '0);
      add(1, 1, 0, 16'h7070, 1, 0, {16'h4040, 16'h5050, 16'h6060, 16'h7070});
      run_table();

      // Async reset between edges after two samples
      add(1, 1, 1, 16'hAAAA, 0, 0, '0);
      add(1, 1, 0, 16'hBBBB, 0, 0, '0);
      run_table();
      #2;
      i_rst = 1'b1;
      #1;
      check("arst_x", {o_x0, o_x1, o_x2, o_x3}, 64'd0);
      check("arst_valid", 64'(o_valid), 64'd0);
      check("arst_drop", 64'(o_drop), 64'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      last_frame = '0;
      // No sof: the first accept after reset must land in slot 0
      add_frame(0, 16'h0F0F, 16'hF0F0, 16'h3C3C, 16'hC3C3);
      run_table();

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
